// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a start/busy/done handshake.
// Single-cycle ops (ADD, SUB, AND, OR, SHL, SHR, PASS) complete on the start
// edge. MUL is an unsigned shift-add that takes WIDTH clocks while busy is high.
// out and the Z/N/C/V flags change only when an operation completes.
module seq_alu #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [2:0]       sel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             Z,
   output logic             N,
   output logic             C,
   output logic             V
);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_MUL  = 3'b100;
   localparam logic [2:0] OP_SHL  = 3'b101;
   localparam logic [2:0] OP_SHR  = 3'b110;
   localparam logic [2:0] OP_PASS = 3'b111;

   localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

   typedef enum logic {IDLE, MUL} state_t;

   state_t               state_q, state_d;
   logic [SHW-1:0]       cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand, shifted left each iteration
   logic [WIDTH-1:0]     mplier_q, mplier_d; // multiplier, shifted right each iteration
   logic [2*WIDTH-1:0]   prod_q, prod_d;     // partial product
   logic [2*WIDTH-1:0]   prod_sum;
   logic [WIDTH-1:0]     out_d;
   logic                 z_d, n_d, c_d, v_d, done_d;

   // Single-cycle datapath; one extra bit on each side catches carry/borrow
   // and the last bit shifted out.
   logic [SHW-1:0]       amt;
   logic [WIDTH:0]       sum_w, diff_w, shl_w, shr_w;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_c, alu_v;

   assign amt    = in2[SHW-1:0];
   assign sum_w  = {1'b0, in1} + {1'b0, in2};
   assign diff_w = {1'b0, in1} - {1'b0, in2};
   assign shl_w  = {1'b0, in1} << amt;
   assign shr_w  = {in1, 1'b0} >> amt;

   assign busy = (state_q == MUL);

   // Result and carry/overflow for the single-cycle opcodes.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (sel)
         OP_ADD: begin
            alu_res = sum_w[WIDTH-1:0];
            alu_c   = sum_w[WIDTH];
            alu_v   = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum_w[WIDTH-1] != in1[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff_w[WIDTH-1:0];
            alu_c   = diff_w[WIDTH];
            alu_v   = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff_w[WIDTH-1] != in1[WIDTH-1]);
         end
         OP_AND:  alu_res = in1 & in2;
         OP_OR:   alu_res = in1 | in2;
         OP_SHL: begin
            alu_res = shl_w[WIDTH-1:0];
            alu_c   = shl_w[WIDTH];
         end
         OP_SHR: begin
            alu_res = shr_w[WIDTH:1];
            alu_c   = shr_w[0];
         end
         OP_PASS: alu_res = in2;
         default: alu_res = '0;
      endcase
   end

   // Next-state logic: handshake FSM, shift-add iteration and result/flag update.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      out_d    = out;
      z_d      = Z;
      n_d      = N;
      c_d      = C;
      v_d      = V;
      done_d   = 1'b0;
      prod_sum = prod_q + (mplier_q[0] ? mcand_q : '0);

      case (state_q)
         IDLE: begin
            if (start) begin
               if (sel == OP_MUL) begin
                  mcand_d  = {{WIDTH{1'b0}}, in1};
                  mplier_d = in2;
                  prod_d   = '0;
                  cnt_d    = '0;
                  state_d  = MUL;
               end else begin
                  out_d  = alu_res;
                  z_d    = (alu_res == '0);
                  n_d    = alu_res[WIDTH-1];
                  c_d    = alu_c;
                  v_d    = alu_v;
                  done_d = 1'b1;
               end
            end
         end
         MUL: begin
            prod_d   = prod_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + SHW'(1);
            if (cnt_q == LAST_ITER) begin
               state_d = IDLE;
               out_d   = prod_sum[WIDTH-1:0];
               z_d     = (prod_sum[WIDTH-1:0] == '0);
               n_d     = prod_sum[WIDTH-1];
               c_d     = |prod_sum[2*WIDTH-1:WIDTH];
               v_d     = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, multiplier datapath and output registers; reset discards any in-flight multiply.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         out      <= '0;
         Z        <= 1'b0;
         N        <= 1'b0;
         C        <= 1'b0;
         V        <= 1'b0;
         done     <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         out      <= out_d;
         Z        <= z_d;
         N        <= n_d;
         C        <= c_d;
         V        <= v_d;
         done     <= done_d;
      end
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational 8-bit ALU in the processor datapath.
- Generalises operand width and adds a start/busy/done handshake.
- Adds an iterative shift-add multiplier (multi-cycle), barrel shifts, and a full Z/N/C/V flag set. All outputs are registered.
- Sits between the register file operand muxes and the write-back stage. The control unit stalls on busy.

Parameters:
- WIDTH, 8, operand/result width in bits. Power of two, 4..32.
- SHW, $clog2(WIDTH), shift-amount field width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  operation request, sampled on clk rising edge when busy=0
- in1  input  WIDTH  operand A
- in2  input  WIDTH  operand B / shift amount
- sel  input  3  opcode
- busy  output  1  high while a multi-cycle operation is in progress
- done  output  1  one-cycle pulse; result valid
- out  output  WIDTH  registered result
- Z  output  1  zero flag
- N  output  1  negative flag (out[WIDTH-1])
- C  output  1  carry/borrow/overflow-out flag
- V  output  1  signed overflow flag

Behaviour:
- Reset (rst_n=0, asynchronous, any state including mid-multiply):
  - out=0, Z=0, N=0, C=0, V=0, busy=0, done=0.
  - FSM goes to IDLE; iteration counter and partial product are cleared.
  - Any in-flight operation is discarded with no done pulse.
- FSM states: IDLE, MUL.
  - IDLE: when start=1, decode sel.
  - sel=100: latch in1/in2 into internal registers, load partial product 0, counter 0, busy=1, go to MUL.
  - All other sel values: compute, register out and flags on the same edge, done=1 for the next cycle, stay in IDLE.
  - MUL: one shift-add iteration per clock over latched operands (unsigned). After the WIDTH-th iteration edge:
    - out = low WIDTH bits of the product.
    - flags updated.
    - busy=0, done=1 for one cycle, return to IDLE.
- Latency:
  - Single-cycle ops: done high in the cycle after the start edge. start may be asserted every cycle, giving one result per cycle.
  - MUL: busy high for exactly WIDTH cycles starting the cycle after the start edge. done high in the cycle after busy falls. A new start is accepted in that done cycle.
- start while busy=1: ignored. No effect on operands, state or outputs. in1/in2/sel may change freely during MUL.
- Opcodes:
  - 000 ADD: in1+in2
  - 001 SUB: in1-in2
  - 010 AND
  - 011 OR
  - 100 MUL: unsigned
  - 101 SHL: in1 << in2[SHW-1:0]
  - 110 SHR: logical, in1 >> in2[SHW-1:0]
  - 111 PASS: out=in2
- Flags, updated only on completion:
  - Z = (out==0).
  - N = out[WIDTH-1].
  - C, ADD: carry-out.
  - C, SUB: borrow, i.e. in1<in2 unsigned.
  - C, MUL: 1 if the high WIDTH bits of the full product are nonzero.
  - C, SHL/SHR: last bit shifted out; 0 when the shift amount is 0.
  - C, AND/OR/PASS: 0.
  - V, ADD/SUB: two's-complement signed overflow. V is 0 for all other ops.
- Hold: out and flags hold their value until the next completed operation. done is 0 except on the single completion cycle.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH. Shift amounts are taken modulo WIDTH via the truncated field.

Test Plan (WIDTH=8):
- Reset, then ADD 2+4, then ADD 5+3 on consecutive cycles → out=6 (Z=0, C=0, V=0), then out=8 on the next cycle. Each result has a one-cycle done pulse and busy stays 0.
- ADD 200+100 → out=44, C=1, V=0. ADD 100+100 → out=200, N=1, V=1, C=0. SUB 3-3 → out=0, Z=1, C=0. SUB 1-3 → out=254, N=1, C=1, V=0.
- MUL 1×3 → busy high 8 cycles, then out=3, C=0, done pulse. MUL 20×20 → out=144, C=1. Start pulses with other operands during busy are ignored; the result is unchanged.
- SHL 0x81 by 1 → out=0x02, C=1. SHR 0x81 by 1 → out=0x40, C=1. SHL 0x81 by 9 (in2=9, amount 1) → out=0x02. SHR by 0 → out=0x81, C=0.
- Assert rst_n=0 asynchronously (mid-cycle) on the 4th busy cycle of MUL 15×15 → busy, done, out and all flags go to 0 immediately with no done pulse. After release, ADD 1+1 → out=2 on the next done.
- PASS in2=0 → out=0, Z=1, C=0, V=0. Then AND 0xF0&0x0F → out=0, Z=1. OR → out=0xFF, N=1.
